sobel_frame_sequencer: RTL

Frame-level controller for the Sobel edge-detection core. Accepts a raw 8-bit grey pixel stream over a valid/ready handshake and generates raster coordinates and the valid strobe for the core. Latches a per-frame threshold and re-tags the core's output with delayed coordinates. Signals frame completion after the core pipeline drains. Sits between the camera/frame-buffer reader and the Sobel core; its output feeds the VGA/frame-buffer writer.

---
 rtl/sobel_frame_sequencer_if.sv | 27 ++
 rtl/sobel_frame_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sequencer_if.sv
// Pixel stream bundle around the Sobel frame sequencer.
//   s_*  : raw grey pixel stream into the sequencer (valid/ready, sof marker)
//   m_*  : re-tagged binary pixel stream out of the sequencer (no backpressure)
// Modports:
//   master : source of s_*, sink of m_* (camera reader / frame writer side)
//   slave  : the sequencer itself
interface sobel_frame_sequencer_if;
  logic [7:0] s_pixel;
  logic       s_valid;
  logic       s_sof;
  logic       s_ready;
  logic [7:0] m_pixel;
  logic       m_valid;
  logic [8:0] m_x;
  logic [7:0] m_y;
  logic       m_last;

  modport master (
    output s_pixel, s_valid, s_sof,
    input  s_ready, m_pixel, m_valid, m_x, m_y, m_last
  );

  modport slave (
    input  s_pixel, s_valid, s_sof,
    output s_ready, m_pixel, m_valid, m_x, m_y, m_last
  );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Frame-level controller for the Sobel core.
// Generates raster coordinates for an incoming pixel stream, latches a
// per-frame threshold, re-tags the core result with coordinates delayed by
// the core latency, and pulses frame_done once the core has drained.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : frame start request (honoured in IDLE only)
//   threshold_cfg   : threshold, sampled on accepted start
//   io (slave)      : s_* input stream, m_* tagged output stream
//   core_*          : pixel/valid/coords/threshold to core, core_pixel_out back
//   busy            : RUN or FLUSH
//   frame_done      : one-cycle end-of-frame pulse
//   sof_error       : sticky, s_sof seen away from (0,0)
module sobel_frame_sequencer #(
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int CORE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            threshold_cfg,
  sobel_frame_sequencer_if.slave io,
  output logic [7:0]            core_pixel,
  output logic                  core_valid,
  output logic [8:0]            core_x,
  output logic [7:0]            core_y,
  output logic [7:0]            core_threshold,
  input  logic [7:0]            core_pixel_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sof_error
);

  localparam int DC_W = $clog2(CORE_LATENCY + 1);
  localparam logic [8:0]      X_MAX  = 9'(IMG_WIDTH - 1);
  localparam logic [7:0]      Y_MAX  = 8'(IMG_HEIGHT - 1);
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(CORE_LATENCY - 1);
  localparam logic [DC_W-1:0] DC_ONE = DC_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [8:0]      x;
  logic [7:0]      y;
  logic [DC_W-1:0] drain;
  logic            accept, resync, is_last;
  logic [8:0]      cur_x;
  logic [7:0]      cur_y;

  // Tag pipeline, stage 1 is the head register, CORE_LATENCY the tail.
  logic [CORE_LATENCY:1]       vld_pipe;
  logic [CORE_LATENCY:1]       last_pipe;
  logic [CORE_LATENCY:1][8:0]  x_pipe;
  logic [CORE_LATENCY:1][7:0]  y_pipe;

  assign accept = io.s_valid && (state == RUN);

  // s_sof forces the pixel to the origin; off-origin it is also an error.
  assign cur_x   = io.s_sof ? 9'd0 : x;
  assign cur_y   = io.s_sof ? 8'd0 : y;
  assign resync  = accept && io.s_sof && !(x == 9'd0 && y == 8'd0);
  assign is_last = (cur_x == X_MAX) && (cur_y == Y_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && is_last) state_nxt = FLUSH;
      FLUSH:   if (drain == DC_MAX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      drain          <= '0;
      core_threshold <= '0;
      sof_error      <= 1'b0;
      vld_pipe       <= '0;
      last_pipe      <= '0;
      x_pipe         <= '0;
      y_pipe         <= '0;
    end else begin
      state <= state_nxt;
      drain <= (state == FLUSH) ? drain + DC_ONE : '0;

      if (state == IDLE && start) begin
        core_threshold <= threshold_cfg;
        x              <= '0;
        y              <= '0;
        sof_error      <= 1'b0;
      end

      if (resync) sof_error <= 1'b1;

      if (accept) begin
        if (cur_x == X_MAX) begin
          x <= '0;
          y <= (cur_y == Y_MAX) ? 8'd0 : cur_y + 8'd1;
        end else begin
          x <= cur_x + 9'd1;
          y <= cur_y;
        end
      end

      // Free-running shift so the tail lines up with the stall-free core.
      for (int i = CORE_LATENCY; i > 1; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        x_pipe[i]    <= x_pipe[i-1];
        y_pipe[i]    <= y_pipe[i-1];
      end
      vld_pipe[1]  <= accept;
      last_pipe[1] <= accept && is_last;
      x_pipe[1]    <= core_x;
      y_pipe[1]    <= core_y;
    end
  end

  assign io.s_ready = (state == RUN);
  assign core_valid = accept;
  assign core_pixel = accept ? io.s_pixel : 8'd0;
  assign core_x     = accept ? cur_x : 9'd0;
  assign core_y     = accept ? cur_y : 8'd0;

  assign io.m_valid = vld_pipe[CORE_LATENCY];
  assign io.m_pixel = vld_pipe[CORE_LATENCY] ? core_pixel_out : 8'd0;
  assign io.m_x     = x_pipe[CORE_LATENCY];
  assign io.m_y     = y_pipe[CORE_LATENCY];
  assign io.m_last  = last_pipe[CORE_LATENCY];

  assign busy       = (state == RUN) || (state == FLUSH);
  assign frame_done = (state == DONE);

endmodule
